hamming_tx_serializer: RTL and testbench
========================================

Name: hamming_tx_serializer

Overview:
Upstream neighbour of the Hamming(7,4) decoder, serving as its transmit/serial-link stage.
- Accepts 4-bit data nibbles over a valid/ready handshake.
- Encodes each nibble into a 7-bit codeword in the exact bit layout the decoder expects.
- Shifts the codeword out one bit per cycle, MSB first, with frame markers.
- Optionally flips one codeword bit per frame, so benches can exercise the decoder's single-error correction.

Parameters:
GAP, 0, idle cycles inserted after the last bit of each frame before returning to IDLE (0..15)
CNT_W, 8, width of the accepted-frame counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
din  input  4  data nibble {d3,d2,d1,d0}
din_valid  input  1  din and inj_pos are valid
din_ready  output  1  block can accept a nibble this cycle
inj_pos  input  3  error injection position, sampled with din; 0 = none, 1..7 = flip H[inj_pos-1]
tx_bit  output  1  serial codeword bit
tx_valid  output  1  tx_bit is valid
tx_sof  output  1  high with the first bit (H[6]) of each frame
busy  output  1  state != IDLE
frame_cnt  output  CNT_W  count of accepted nibbles, wraps modulo 2^CNT_W

Behaviour:
- Codeword layout, H[6:0] = {d3, d2, d1, p4, d0, p2, p1}:
  - p4 = d3^d2^d1
  - p2 = d3^d2^d0
  - p1 = d3^d1^d0
  - A clean codeword gives zero syndrome at the decoder, and the decoder returns D = {H6,H5,H4,H2} = din.
- Injection: if inj_pos != 0, the stored codeword is H ^ (1 << (inj_pos-1)). The decoder's syndrome then equals inj_pos.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: din_ready=1. On din_valid, load shift register with the (possibly injected) codeword, clear bit counter, increment frame_cnt, go to SHIFT.
  - SHIFT: din_ready=0, tx_valid=1, tx_bit=shreg[6], tx_sof=1 only when bit counter = 0. Shift left each cycle. After 7 bits (counter = 6): go to GAP if GAP > 0, else IDLE.
  - GAP: tx_valid=0, din_ready=0. Count GAP cycles, then go to IDLE.
- Handshake: transfer occurs at the rising edge where din_valid && din_ready.
  - din_ready is driven purely from state (no combinational path from din_valid).
  - din_valid held while din_ready=0 is ignored; no loss, the source holds it.
- Latency: accept at edge N; first bit (tx_sof=1) is valid in the cycle after edge N, and the last bit 6 cycles later.
- Throughput: one frame every 8+GAP cycles (IDLE accept cycle + 7 bits + GAP).
- All outputs are registered or decoded from registered state. tx_bit=0 whenever tx_valid=0.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE; shreg, bit counter, gap counter, frame_cnt = 0.
  - tx_valid, tx_sof, tx_bit, busy = 0; din_ready=1 once reset deasserts.
  - A partial frame is abandoned and never resumed.
- frame_cnt wraps 2^CNT_W-1 -> 0 silently.
- inj_pos values are used as given; all 3-bit values are legal.

Decomposition:
- Shared package (hamming_pkg): state encoding (IDLE/SHIFT/GAP), CW_W=7, DATA_W=4, and the parity equations as a function hamming_encode(d) -> [6:0].
- Sub-module hamming_encode: combinational 4 -> 7 encoder using that function. It is reused by future parallel paths and by the bench scoreboard.
- The FSM, shift register and counters stay in hamming_tx_serializer.

Test Plan:
- din=4'b1011, inj_pos=0, GAP=0 -> frame bits 1,0,1,0,1,0,1 (H=7'b1010101), tx_sof on the first bit only, first bit 1 cycle after accept; decoder on the deserialised word gives Err=0, D=1011.
- Back-to-back din=4'h0 then 4'hF, din_valid held high, GAP=0 -> 0000000 then 1111111; second frame's sof 8 cycles after the first; din_ready low during SHIFT; frame_cnt = 2.
- din=4'b1011, inj_pos=3 -> H=7'b1010001; decoder gives Err=1, syndrome 3, D=1011. Sweep inj_pos 1..7 for all 16 nibbles -> D always equals din.
- GAP=3 -> tx_valid low for exactly 3 cycles after bit 7, then din_ready high; busy high through SHIFT and GAP.
- Assert rst at bit 4 of a frame -> tx_valid/busy drop immediately, frame_cnt=0; a new nibble is accepted after release and its frame is complete and correct.
- CNT_W=2, send 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) constants, FSM state encoding and encoder function
// Layout H[6:0] = {d3,d2,d1,p4,d0,p2,p1}. This is the codeword order the downstream decoder expects.
package hamming_pkg;
   localparam int CW_W = 7;
   localparam int DATA_W = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
   function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
      return {d[3], d[2], d[1], d[3]^d[2]^d[1], d[0], d[3]^d[2]^d[0], d[3]^d[1]^d[0]};
   endfunction
endpackage

// File: rtl/hamming_tx_serializer_if.sv
// hamming_tx_serializer_if: nibble handshake plus serial frame output of the serializer
// master: nibble source and frame sink (bench or upstream logic); slave: the serializer
interface hamming_tx_serializer_if
   import hamming_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic [DATA_W-1:0] din;
   logic din_valid;
   logic din_ready;
   logic [2:0] inj_pos;
   logic tx_bit;
   logic tx_valid;
   logic tx_sof;
   logic busy;
   logic [CNT_W-1:0] frame_cnt;
   modport master (output din, din_valid, inj_pos, input din_ready, tx_bit, tx_valid, tx_sof, busy, frame_cnt);
   modport slave (input din, din_valid, inj_pos, output din_ready, tx_bit, tx_valid, tx_sof, busy, frame_cnt);
endinterface

// File: rtl/hamming_tx_serializer_encode.sv
// hamming_encode: combinational 4-bit to 7-bit Hamming encoder
// d: data nibble {d3,d2,d1,d0}; cw: codeword {d3,d2,d1,p4,d0,p2,p1}
module hamming_encode
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   output logic [CW_W-1:0]   cw
);
   assign cw = hamming_pkg::hamming_encode(d);
endmodule

// File: rtl/hamming_tx_serializer.sv
// hamming_tx_serializer: accepts nibbles, Hamming(7,4)-encodes them and shifts the codeword out MSB first
// clk, rst: clock and async active-high reset; bus: nibble input handshake, serial output, busy, frame_cnt
module hamming_tx_serializer
   import hamming_pkg::*;
#(
   parameter int GAP = 0,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic rst,
   hamming_tx_serializer_if.slave bus
);
   localparam logic [3:0] GAP_LAST = 4'(GAP == 0 ? 0 : GAP - 1);
   state_t state, nstate;
   logic [CW_W-1:0] cw, cw_inj, shreg;
   logic [2:0] bcnt;
   logic [3:0] gcnt;
   logic [CNT_W-1:0] cnt;
   logic accept;
   hamming_encode u_enc (.d(bus.din), .cw(cw));
   // inj_pos is 1-based so that it equals the syndrome the decoder will report
   assign cw_inj = bus.inj_pos == 3'd0 ? cw : cw ^ (7'd1 << (bus.inj_pos - 3'd1));
   assign accept = state == ST_IDLE && bus.din_valid;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else state <= nstate;
   always_comb begin
      nstate = state;
      if (state == ST_IDLE) nstate = bus.din_valid ? ST_SHIFT : ST_IDLE;
      else if (state == ST_SHIFT) nstate = bcnt == 3'd6 ? (GAP > 0 ? ST_GAP : ST_IDLE) : ST_SHIFT;
      else nstate = gcnt == GAP_LAST ? ST_IDLE : ST_GAP;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shreg <= '0;
         bcnt <= '0;
         gcnt <= '0;
         cnt <= '0;
      end else begin
         if (accept) begin
            shreg <= cw_inj;
            bcnt <= '0;
            cnt <= cnt + 1'b1;
         end else if (state == ST_SHIFT) begin
            shreg <= shreg << 1;
            bcnt <= bcnt + 3'd1;
         end
         gcnt <= state == ST_GAP ? gcnt + 4'd1 : 4'd0;
      end
   always_comb begin
      bus.din_ready = state == ST_IDLE;
      bus.tx_valid = state == ST_SHIFT;
      bus.tx_bit = state == ST_SHIFT && shreg[CW_W-1];
      bus.tx_sof = state == ST_SHIFT && bcnt == 3'd0;
      bus.busy = state != ST_IDLE;
      bus.frame_cnt = cnt;
   end
endmodule

// File: tb/tb_hamming_tx_serializer.sv
// tb_hamming_tx_serializer: directed checks of three serializer instances (GAP=0, GAP=3, CNT_W=2)
module tb_hamming_tx_serializer;
   logic clk = 0, rst = 1;
   logic [3:0] din = '0;
   logic [2:0] inj = '0;
   logic v0 = 0, v3 = 0, v2 = 0;
   int nvec = 0, nerr = 0;
   always #5 clk = ~clk;
   hamming_tx_serializer_if #(.CNT_W(8)) b0 ();
   hamming_tx_serializer_if #(.CNT_W(8)) b3 ();
   hamming_tx_serializer_if #(.CNT_W(2)) b2 ();
   assign b0.din = din; assign b0.inj_pos = inj; assign b0.din_valid = v0;
   assign b3.din = din; assign b3.inj_pos = inj; assign b3.din_valid = v3;
   assign b2.din = din; assign b2.inj_pos = inj; assign b2.din_valid = v2;
   hamming_tx_serializer #(.GAP(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
   hamming_tx_serializer #(.GAP(3), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(b3));
   hamming_tx_serializer #(.GAP(0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

   typedef struct {
      logic [3:0] d;
      logic [2:0] p;
      logic [6:0] h;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent decoder: returns {syndrome, corrected data}
   function automatic logic [6:0] dec(input logic [6:0] h);
      logic [2:0] s;
      logic [6:0] c;
      s = {h[3]^h[4]^h[5]^h[6], h[1]^h[2]^h[5]^h[6], h[0]^h[2]^h[4]^h[6]};
      c = h;
      if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
      return {s, c[6], c[5], c[4], c[2]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one nibble to u0 and collects its 7-bit frame; ok covers handshake bound, valid and sof framing
   task automatic send0(input logic [3:0] d, input logic [2:0] p, output logic [6:0] w, output logic ok);
      int n = 0;
      while (!b0.din_ready && n < 50) begin step(); n++; end
      din = d; inj = p; v0 = 1;
      step();
      v0 = 0;
      ok = n < 50;
      w = '0;
      for (int i = 0; i < 7; i++) begin
         w = {w[5:0], b0.tx_bit};
         ok &= b0.tx_valid && (b0.tx_sof == (i == 0));
         step();
      end
      ok &= !b0.tx_valid;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] w, w2;
      logic ok;
      logic [15:0] vm, sm, rm;
      logic [11:0] gv, gb, gr;
      logic [7:0] fc0;
      int n;
      tbl[0] = '{4'b1011, 3'd0, 7'b1010101};
      tbl[1] = '{4'b0000, 3'd0, 7'b0000000};
      tbl[2] = '{4'b1111, 3'd0, 7'b1111111};
      tbl[3] = '{4'b0001, 3'd0, 7'b0000111};
      tbl[4] = '{4'b0110, 3'd0, 7'b0110011};
      tbl[5] = '{4'b1000, 3'd0, 7'b1001011};
      tbl[6] = '{4'b1011, 3'd3, 7'b1010001};
      tbl[7] = '{4'b0110, 3'd7, 7'b1110011};
      tbl[8] = '{4'b1111, 3'd4, 7'b1110111};

      step(); step();
      chk("rst_tx_valid", 32'(b0.tx_valid), 0);
      chk("rst_busy", 32'(b0.busy), 0);
      chk("rst_frame_cnt", 32'(b0.frame_cnt), 0);
      chk("rst_tx_bit", 32'(b0.tx_bit), 0);
      rst = 0;
      step();
      chk("rst_release_ready", 32'(b0.din_ready), 1);

      foreach (tbl[k]) begin
         send0(tbl[k].d, tbl[k].p, w, ok);
         chk($sformatf("tbl%0d_word", k), 32'(w), 32'(tbl[k].h));
         chk($sformatf("tbl%0d_framing", k), 32'(ok), 1);
         chk($sformatf("tbl%0d_decode", k), 32'(dec(w)), 32'({tbl[k].p, tbl[k].d}));
      end
      chk("frame_cnt_after_tbl", 32'(b0.frame_cnt), 9);

      fc0 = b0.frame_cnt;
      din = 4'h0; inj = 3'd0; v0 = 1;
      step();
      din = 4'hF;
      vm = '0; sm = '0; rm = '0; w = '0; w2 = '0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) v0 = 0;
         vm[i] = b0.tx_valid; sm[i] = b0.tx_sof; rm[i] = b0.din_ready;
         if (i < 7) w = {w[5:0], b0.tx_bit};
         if (i >= 8 && i < 15) w2 = {w2[5:0], b0.tx_bit};
         step();
      end
      chk("b2b_word1", 32'(w), 32'h00);
      chk("b2b_word2", 32'(w2), 32'h7F);
      chk("b2b_sof", 32'(sm), 32'h0101);
      chk("b2b_valid", 32'(vm), 32'h7F7F);
      chk("b2b_ready", 32'(rm), 32'h8080);
      chk("b2b_frame_cnt", 32'(b0.frame_cnt - fc0), 2);

      for (int d = 0; d < 16; d++)
         for (int p = 1; p < 8; p++) begin
            send0(4'(d), 3'(p), w, ok);
            chk($sformatf("sweep_d%0d_p%0d", d, p), 32'({ok, dec(w)}), 32'({1'b1, 3'(p), 4'(d)}));
         end

      n = 0;
      while (!b3.din_ready && n < 50) begin step(); n++; end
      chk("gap_ready_wait", 32'(n < 50), 1);
      din = 4'b0110; inj = 3'd0; v3 = 1;
      step();
      v3 = 0;
      w = '0;
      for (int i = 0; i < 12; i++) begin
         gv[i] = b3.tx_valid; gb[i] = b3.busy; gr[i] = b3.din_ready;
         if (i < 7) w = {w[5:0], b3.tx_bit};
         step();
      end
      chk("gap_word", 32'(w), 32'b0110011);
      chk("gap_valid", 32'(gv), 32'h07F);
      chk("gap_busy", 32'(gb), 32'h3FF);
      chk("gap_ready", 32'(gr), 32'hC00);

      din = 4'b1000; inj = 3'd0; v0 = 1;
      step();
      v0 = 0;
      step(); step(); step();
      chk("mid_valid_before_rst", 32'(b0.tx_valid), 1);
      rst = 1;
      #1;
      chk("mid_rst_valid", 32'(b0.tx_valid), 0);
      chk("mid_rst_busy", 32'(b0.busy), 0);
      chk("mid_rst_frame_cnt", 32'(b0.frame_cnt), 0);
      chk("mid_rst_sof", 32'(b0.tx_sof), 0);
      step();
      rst = 0;
      chk("mid_release_ready", 32'(b0.din_ready), 1);
      send0(4'b0001, 3'd0, w, ok);
      chk("mid_new_word", 32'(w), 32'b0000111);
      chk("mid_new_framing", 32'(ok), 1);
      chk("mid_new_frame_cnt", 32'(b0.frame_cnt), 1);

      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (!b2.din_ready && n < 50) begin step(); n++; end
         din = 4'(k); v2 = 1;
         step();
         v2 = 0;
         chk($sformatf("cnt2_frame%0d", k), 32'(b2.frame_cnt), 32'((k + 1) % 4));
         repeat (7) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
